// File: rtl/sram_stream_reader.sv
// sram_stream_reader: credit-limited sequential SRAM block reader feeding a valid/ready byte stream; define SRAM_READER_LOOP_EN for the looping mode
module sram_stream_reader #(
  parameter int AW = 19,
  parameter int DW = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
`ifdef SRAM_READER_LOOP_EN
  input  logic          loop,
`endif
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_en,
  output logic          mem_we,
  input  logic          mem_busy,
  input  logic          mem_valid,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_n;
  logic [AW-1:0] addr;
  logic [AW:0] remaining;
  logic [CW-1:0] outstanding, fifo_count;
  logic [DW-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic accept, push, pop, last, reload, go, drained, done_n;
`ifdef SRAM_READER_LOOP_EN
  logic [AW-1:0] base_r;
  logic [AW:0] len_r;
  assign reload = last && loop;
`else
  assign reload = 1'b0;
`endif
  assign mem_we = 1'b0;
  assign mem_addr = addr;
  assign busy = state != IDLE;
  assign m_valid = fifo_count != '0;
  assign m_data = m_valid ? fifo[rd_ptr] : '0;
  assign push = mem_valid && outstanding != '0;
  assign pop = m_valid && m_ready;
  assign go = start && length != '0;
  assign drained = outstanding == '0 && fifo_count == '0;
  // request gating by credit, and next-state / completion decode
  always_comb begin
    mem_en = state == ISSUE && remaining != '0 && ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(FIFO_DEPTH);
    accept = mem_en && !mem_busy;
    last = accept && remaining == (AW+1)'(1);
    state_n = state;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        state_n = go ? ISSUE : IDLE;
        done_n = start && !go;
      end
      ISSUE: state_n = (last && !reload) ? DRAIN : ISSUE;
      DRAIN: begin
        state_n = drained ? IDLE : DRAIN;
        done_n = drained;
      end
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // address/length walk, read credits and FIFO occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      remaining <= '0;
      outstanding <= '0;
      fifo_count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      done <= 1'b0;
    end else begin
      done <= done_n;
      outstanding <= outstanding + CW'(accept) - CW'(push);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (state == IDLE && go) begin
        addr <= base_addr;
        remaining <= length;
`ifdef SRAM_READER_LOOP_EN
      end else if (reload) begin
        addr <= base_r;
        remaining <= len_r;
`endif
      end else if (accept) begin
        addr <= addr + AW'(1);
        remaining <= remaining - (AW+1)'(1);
      end
    end
  end
`ifdef SRAM_READER_LOOP_EN
  // pass parameters kept for reloading at the end of each looped pass
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r <= '0;
      len_r <= '0;
    end else if (state == IDLE && go) begin
      base_r <= base_addr;
      len_r <= length;
    end
  end
`endif
  // FIFO storage; flushed through the pointers, so no reset needed
  always_ff @(posedge clk) if (push) fifo[wr_ptr] <= mem_data;
  // credits must make a push into a full FIFO impossible
  always_ff @(posedge clk) if (!rst) assert (!(push && !pop && fifo_count == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_sram_stream_reader.sv
// tb_sram_stream_reader: randomized scoreboard bench with an arbiter/SRAM model
module tb_sram_stream_reader;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int D = 8;
  logic clk = 0, rst = 1, start = 0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] length = '0;
  logic busy, done, mem_en, mem_we, m_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] m_data;
  logic mem_busy = 0, mem_valid = 0, m_ready = 1;
  logic [DW-1:0] mem_data = '0;
`ifdef SRAM_READER_LOOP_EN
  logic loop = 0;
`endif
  int checks = 0, failures = 0, cyc = 0;
  int busy_mode = 0, ready_mode = 0, lat_lo = 1, lat_hi = 1;
  int accepts = 0, done_cnt = 0, d0 = 0, s_cyc = 0, first_acc = -1, last_acc = -1, first_mv = -1, last_due = 0;
  logic saw_valid = 0, prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] exp_data[$], arb_d[$];
  logic [AW-1:0] exp_addr[$];
  int arb_due[$];

  sram_stream_reader #(.AW(AW), .DW(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
`ifdef SRAM_READER_LOOP_EN
    .loop(loop),
`endif
    .start(start), .base_addr(base_addr), .length(length), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_busy(mem_busy),
    .mem_valid(mem_valid), .mem_data(mem_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] sram(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // arbiter + SRAM model: in-order returns with random latency and stalls
  always @(negedge clk) begin
    int due;
    mem_busy = busy_mode == 1 ? (cyc % 2 == 1) : busy_mode == 2 ? ($urandom_range(0, 2) == 0) : 1'b0;
    m_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (arb_due.size() != 0 && arb_due[0] == cyc) begin
      mem_valid = 1;
      mem_data = arb_d.pop_front();
      void'(arb_due.pop_front());
    end else begin
      mem_valid = 0;
      mem_data = DW'($urandom);
    end
    #1;
    if (mem_en && !mem_busy) begin
      due = cyc + $urandom_range(lat_lo, lat_hi);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      arb_due.push_back(due);
      arb_d.push_back(sram(mem_addr));
      accepts++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
  end

  // monitor: pops expected requests and stream words as the DUT presents them
  always @(negedge clk) begin
    #2;
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("addr_hold", mem_addr, prev_addr);
        chk("en_hold", mem_en, 1);
      end
      if (mem_en && !mem_busy) begin
        if (exp_addr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_req: request addr %0h with none expected", mem_addr);
        end else chk("mem_addr", mem_addr, exp_addr.pop_front());
        chk("mem_we", mem_we, 0);
      end
      prev_stall = mem_en && mem_busy;
      prev_addr = mem_addr;
      if (m_valid) begin
        saw_valid = 1;
        if (first_mv < 0) first_mv = cyc;
      end
      if (m_valid && m_ready) begin
        if (exp_data.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_data: stream word %0h with none expected", m_data);
        end else chk("m_data", m_data, exp_data.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk("done_busy", busy, 0);
      end
    end
  end

  task automatic push_exp(input logic [AW-1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(AW'(b + AW'(i)));
      exp_data.push_back(sram(AW'(b + AW'(i))));
    end
  endtask

  task automatic launch(input logic [AW-1:0] b, input int n);
    @(negedge clk);
    start = 1;
    base_addr = b;
    length = (AW+1)'(n);
    push_exp(b, n);
    s_cyc = cyc;
    accepts = 0;
    first_acc = -1;
    first_mv = -1;
    d0 = done_cnt;
    @(negedge clk);
    start = 0;
    base_addr = AW'($urandom);
    length = (AW+1)'($urandom);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 500 && done_cnt == d0; i++) begin
      @(negedge clk);
      #3;
    end
    repeat (3) @(negedge clk);
    #3;
    chk({name, "_done_count"}, done_cnt - d0, 1);
    chk({name, "_busy_after"}, busy, 0);
    chk({name, "_data_left"}, exp_data.size(), 0);
    chk({name, "_req_left"}, exp_addr.size(), 0);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_mem_en"}, mem_en, 0);
    chk({name, "_mem_addr"}, mem_addr, 0);
    chk({name, "_m_valid"}, m_valid, 0);
    chk({name, "_m_data"}, m_data, 0);
    chk({name, "_mem_we"}, mem_we, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #3;
    chk_reset("reset");
    rst = 0;
    // basic four-word read, latency 1, free-flowing stream
    launch(19'h10, 4);
    wait_done("basic");
    chk("basic_first_req", first_acc, s_cyc + 1);
    chk("basic_consecutive", last_acc - first_acc, 3);
    chk("basic_valid_latency", first_mv, first_acc + 2);
    // back-pressure: credits must stop requests at the FIFO depth
    ready_mode = 1;
    launch(19'h200, 20);
    repeat (40) @(negedge clk);
    #3;
    chk("bp_accepts", accepts, D);
    chk("bp_mem_en", mem_en, 0);
    chk("bp_m_valid", m_valid, 1);
    ready_mode = 0;
    wait_done("bp");
    chk("bp_total", accepts, 20);
    // arbiter stalls on alternate cycles
    busy_mode = 1;
    launch(19'h300, 6);
    wait_done("stall");
    chk("stall_accepts", accepts, 6);
    busy_mode = 0;
    // address wrap at the top of memory
    launch(19'h7FFFE, 4);
    wait_done("wrap");
    // empty transfer
    @(negedge clk);
    start = 1;
    base_addr = 19'h55;
    length = '0;
    accepts = 0;
    d0 = done_cnt;
    @(negedge clk);
    start = 0;
    #3;
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    repeat (4) @(negedge clk);
    #3;
    chk("empty_accepts", accepts, 0);
    chk("empty_done_count", done_cnt - d0, 1);
    // start while busy must be ignored
    launch(19'h100, 5);
    @(negedge clk);
    start = 1;
    base_addr = 19'h200;
    length = 9;
    @(negedge clk);
    start = 0;
    wait_done("ignored_start");
    chk("ignored_accepts", accepts, 5);
    // randomized transfers
    for (int t = 0; t < 20; t++) begin
      lat_lo = 1;
      lat_hi = $urandom_range(1, 4);
      busy_mode = 2;
      ready_mode = 2;
      launch(AW'($urandom), $urandom_range(1, 30));
      wait_done("rand");
    end
    busy_mode = 0;
    ready_mode = 0;
    // reset with reads in flight; late returns must be dropped
    lat_lo = 6;
    lat_hi = 6;
    launch(19'h400, 10);
    for (int i = 0; i < 100 && accepts < 3; i++) begin
      @(negedge clk);
      #3;
    end
    chk("midrst_accepts", accepts, 3);
    rst = 1;
    exp_data.delete();
    exp_addr.delete();
    repeat (2) @(negedge clk);
    #3;
    chk_reset("midrst");
    rst = 0;
    saw_valid = 0;
    repeat (12) @(negedge clk);
    #3;
    chk("midrst_no_valid", saw_valid, 0);
    chk("midrst_busy", busy, 0);
    lat_lo = 1;
    lat_hi = 1;
    launch(19'h20, 3);
    wait_done("recover");
`ifdef SRAM_READER_LOOP_EN
    loop = 1;
    launch(19'h40, 3);
    push_exp(19'h40, 3);
    push_exp(19'h40, 3);
    for (int i = 0; i < 100 && accepts < 7; i++) begin
      @(negedge clk);
      #3;
    end
    chk("loop_no_done", done_cnt - d0, 0);
    chk("loop_busy", busy, 1);
    loop = 0;
    wait_done("loop");
    chk("loop_accepts", accepts, 9);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
Sequential read engine on one client port of the SRAM arbiter. On a start pulse it reads a contiguous block of SRAM words and presents them in order on a valid/ready byte stream. Typical consumer: the PWM duty input or an audio sample path. Outstanding reads are credit-limited against an internal FIFO, so arbiter read latency and downstream back-pressure never lose data.

Parameters:
AW, 19, SRAM word-address width
DW, 8, data width
FIFO_DEPTH, 8, output FIFO entries (power of 2, min 2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle start pulse; ignored while busy=1
base_addr  in  AW  first word address, sampled on accepted start
length  in  AW+1  words to read, sampled on accepted start; 0 = empty transfer
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
mem_addr  out  AW  arbiter read address
mem_en  out  1  read request to arbiter
mem_we  out  1  constant 0
mem_busy  in  1  arbiter stall; request not accepted while high
mem_valid  in  1  read data valid, in request order
mem_data  in  DW  read data
m_data  out  DW  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready

Behaviour:
- Reset: busy=0, done=0, mem_en=0, mem_addr=0, m_valid=0, m_data=0, FIFO flushed, outstanding=0, FSM=IDLE. Reset mid-transfer aborts immediately; late mem_valid after reset is discarded.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start && length!=0 -> ISSUE; addr<=base_addr, remaining<=length, busy<=1.
  - start && length==0 -> done=1 the next cycle; busy stays 0; no requests issued.
- ISSUE:
  - mem_en = (remaining!=0) && (fifo_count + outstanding < FIFO_DEPTH); mem_addr = addr.
  - Request accepted on mem_en && !mem_busy: addr<=addr+1 (wraps modulo 2^AW, 2^AW-1 -> 0), remaining<=remaining-1, outstanding+1.
  - mem_addr and mem_en are held stable while mem_busy=1.
  - First mem_en is asserted the cycle after start.
  - Last request accepted -> DRAIN.
- DRAIN: mem_en=0. When outstanding==0 and FIFO empty and no handshake pending: done=1 for one cycle, busy<=0, -> IDLE.
- mem_valid:
  - Pushes mem_data into the FIFO and decrements outstanding.
  - Simultaneous accept and mem_valid leaves outstanding unchanged.
  - mem_valid with outstanding==0 is discarded (no push).
- FIFO:
  - Registered output; m_valid rises the cycle after the first mem_valid.
  - Pop on m_valid && m_ready; m_data is held stable while m_valid && !m_ready.
  - Simultaneous push and pop keeps the count.
  - Credit rule guarantees no push when full; an overflow assertion is required in simulation.
- Counters:
  - remaining is AW+1 bits, so length=2^AW reads the whole memory.
  - outstanding and fifo_count are clog2(FIFO_DEPTH)+1 bits.
- done never coincides with busy rising. A start in the done cycle is accepted, since busy is already 0.

Optional Feature:
SRAM_READER_LOOP_EN
- With it defined:
  - Extra input port loop (1 bit).
  - If loop=1 when the last request of a pass is accepted, addr reloads to the sampled base_addr and remaining to the sampled length. The FSM stays in ISSUE with no gap cycle and no done.
  - Clearing loop lets the current pass finish, then DRAIN/done as normal.
- Without it: no loop port; single pass only.

Test Plan:
- base_addr=0x10, length=4, mem_busy=0, m_ready=1, arbiter latency 1 -> mem_addr 0x10,0x11,0x12,0x13 on consecutive cycles; m_data = SRAM contents in order; exactly one done pulse; busy low after it.
- m_ready=0, length=20, FIFO_DEPTH=8 -> exactly 8 requests accepted, then mem_en=0. m_ready=1 -> remaining 12 words delivered in order with no loss or duplication.
- mem_busy asserted on alternate cycles, length=6 -> mem_addr held during stall; 6 accepts total; stream order intact.
- base_addr=0x7FFFE, length=4 -> addresses 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
- length=0 start -> done one cycle later, mem_en never asserted, busy stays 0. A second start while busy -> ignored; parameters unchanged.
- rst pulsed mid-transfer with 3 reads outstanding -> all outputs return to reset values; following mem_valid pulses produce no m_valid. SRAM_READER_LOOP_EN: loop=1, length=3 -> repeating 3-word sequence with no done until loop cleared.
